// File: rtl/xnand_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits (LSB first), parity, stop -> valid/ready word with PERR/FERR/OVR.
// Build option: define PARITY_ODD_EN for odd parity (XNOR-seeded accumulator); default is even parity.
module xnand_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              PERR,
  output logic              FERR,
  output logic              OVR
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef PARITY_ODD_EN
  // Seeding with 1 turns the XOR chain into XNOR, so p=0 already means "odd parity good".
  localparam logic ACC_SEED = 1'b1;
`else
  localparam logic ACC_SEED = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              acc_reg;
  logic              par_err_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              dvalid_reg;
  logic              perr_reg;
  logic              ferr_reg;
  logic              ovr_reg;
  logic              slot_free;

  // The output slot can take a new frame if empty or being drained this very cycle.
  assign slot_free = !dvalid_reg || DREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= 1'b0;
      par_err_reg <= 1'b0;
      shift_reg   <= '0;
      dout_reg    <= '0;
      dvalid_reg  <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      if (dvalid_reg && DREADY) begin
        dvalid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (!SIN) begin
            state_reg <= DATA;
            cnt_reg   <= '0;
            acc_reg   <= ACC_SEED;
          end
        end
        DATA: begin
          shift_reg[cnt_reg] <= SIN;
          acc_reg            <= acc_reg ^ SIN;
          cnt_reg            <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_reg <= PAR;
          end
        end
        PAR: begin
          par_err_reg <= acc_reg ^ SIN;
          state_reg   <= STOP;
        end
        STOP: begin
          // A low stop bit only flags FERR; we always return to IDLE rather than treat it as a start.
          if (slot_free) begin
            dout_reg   <= shift_reg;
            perr_reg   <= par_err_reg;
            ferr_reg   <= ~SIN;
            dvalid_reg <= 1'b1;
          end else begin
            ovr_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign DOUT   = dout_reg;
  assign DVALID = dvalid_reg;
  assign PERR   = perr_reg;
  assign FERR   = ferr_reg;
  assign OVR    = ovr_reg;

endmodule

// File: doc/xnand_parity_rx.md
# xnand_parity_rx

Serial frame receiver with XOR-tree parity check. It is the receive end of the team's gate-level parity link. The transmit side drives one bit per clock: a start bit, DATA_W data bits, a parity bit and a stop bit. This block deserialises the frame, recomputes parity with a running XOR/XNOR accumulator and checks the stop bit. It then presents the word, plus error flags, on a valid/ready output port for the downstream consumer.

## Interface

- DATA_W, 8, number of data bits per frame (legal range 1..16)
- CLK  input  1  system clock; all logic on the rising edge
- RST  input  1  synchronous, active-high reset
- SIN  input  1  serial line; idles high; one bit per CLK cycle
- DOUT  output  DATA_W  received data word; bit 0 is the first data bit on the line
- DVALID  output  1  DOUT, PERR and FERR hold a received frame
- DREADY  input  1  consumer accepts the word in any cycle where DVALID && DREADY
- PERR  output  1  parity mismatch for the word on DOUT; qualified by DVALID
- FERR  output  1  stop bit was 0 for the word on DOUT; qualified by DVALID
- OVR  output  1  sticky overrun flag; cleared only by RST

## Operation

- The FSM has four states: IDLE, DATA, PAR and STOP.
- IDLE:
  - SIN=0 is a start bit: go to DATA, clear the bit counter and clear the accumulator ACC.
  - SIN=1: stay in IDLE.
- DATA:
  - Shift SIN into the shift register LSB-first.
  - Update ACC = ACC ^ SIN and increment the counter.
  - After DATA_W bits, go to PAR.
- PAR:
  - Capture the parity flag p = ACC ^ SIN; the expected (even) value is p=0.
  - Go to STOP.
- STOP:
  - Sample SIN as the stop bit; f = ~SIN.
  - Complete the frame (see below) and go to IDLE.
  - A stop bit of 0 is never reinterpreted as a start bit.
- Frame completion when the output slot is free (DVALID=0), or is freed this cycle (DVALID && DREADY):
  - Load DOUT from the shift register, PERR=p, FERR=f.
  - Set DVALID=1 from the next cycle.
- Frame completion when the slot is occupied and not accepted this cycle:
  - Discard the new frame and set OVR=1.
  - DOUT, PERR, FERR and DVALID keep the old frame unchanged.
- DVALID && DREADY with no completion in the same cycle: DVALID=0 next cycle. DOUT, PERR and FERR keep their last values.
- Errors do not suppress delivery. A bad frame is delivered with PERR and/or FERR set, and the consumer decides what to do with it.
- Reset values:
  - DOUT=0, DVALID=0, PERR=0, FERR=0, OVR=0.
  - FSM in IDLE, counter 0, ACC 0.
- RST mid-frame aborts the frame with no output. The next frame is recognised from the first SIN=0 sampled after RST is released.
- SIN is assumed synchronous to CLK. This block has no synchroniser and no oversampling.

## Timing

- With the start bit sampled in cycle 0:
  - data bits are sampled in cycles 1..DATA_W;
  - parity in cycle DATA_W+1;
  - stop in cycle DATA_W+2;
  - DVALID rises in cycle DATA_W+3 (cycle 11 for DATA_W=8).
- Frame length is DATA_W+3 cycles. Back-to-back frames are supported: the next start bit may appear in the cycle right after the stop bit.
- DVALID stays high until the handshake. With DREADY held at 1, DVALID is a one-cycle pulse per frame.
- DOUT, PERR and FERR are stable for as long as DVALID=1.
- There is no combinational path from any input to any output. All outputs are registered.

## Configuration

- PARITY_ODD_EN:
  - Undefined: even parity. A frame is good when the XOR of the data bits and the parity bit is 0, so PERR = p.
  - Defined: odd parity, using an XNOR accumulator seed. A frame is good when that XOR is 1, so PERR = ~p.
  - The frame format, timing and all other behaviour are identical in both builds.

## Test plan

- Good frame: DATA_W=8, DREADY=1, send 0xA5, parity 0, stop 1 → DOUT=0xA5, PERR=0, FERR=0, one-cycle DVALID pulse in cycle 11.
- Odd-weight word: send 0x07, parity 1 → PERR=0. Same frame with parity 0 → PERR=1, DOUT=0x07. In the PARITY_ODD_EN build these two results are swapped.
- Framing error: send 0x3C with correct parity and stop bit 0 → DOUT=0x3C, FERR=1, FSM returns to IDLE. A start bit in the next cycle receives correctly.
- Backpressure and overrun:
  - Hold DREADY=0 and send 0x11 then 0x22 back-to-back → DOUT stays 0x11 and OVR=1.
  - Raise DREADY → 0x11 is accepted and DVALID=0.
  - A simultaneous complete-and-accept loads the new word with no OVR.
- Reset mid-frame: assert RST for 1 cycle after 4 data bits → all outputs are 0. A following frame 0x5A is received correctly and OVR stays 0.
